bootrom_axi_resp: RTL and testbench
===================================

BOOTROM_AXI_RESP -- requirements
Module: bootrom_axi_resp

Interface
REQ-001 SHALL have parameter AddrWidth, default 64, the AXI address width.
REQ-002 SHALL have parameter DataWidth, default 64, the AXI data width; only 64 is supported.
REQ-003 SHALL have parameter IdWidth, default 4, the AXI ID width.
REQ-004 SHALL have parameter BaseAddr, default 64'h1_0000, the ROM window base.
REQ-005 SHALL have parameter RomBytes, default 64'h1_0000, the ROM window length.
REQ-006 SHALL have port clk_i, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 SHALL have port rst_ni, input, 1 bit: asynchronous active-low reset.
REQ-008 SHALL have AR channel ports arvalid_i, arready_o, arid_i[IdWidth], araddr_i[AddrWidth], arlen_i[8], arsize_i[3], arburst_i[2].
REQ-009 SHALL have R channel ports rvalid_o, rready_i, rid_o[IdWidth], rdata_o[64], rresp_o[2], rlast_o.
REQ-010 SHALL have AW channel ports awvalid_i, awready_o, awid_i[IdWidth], W channel ports wvalid_i, wready_o, wlast_i, and B channel ports bvalid_o, bready_i, bid_o[IdWidth], bresp_o[2].
REQ-011 SHALL have ROM ports rom_req_o (1 bit), rom_addr_o[log2(RomBytes/8)] (word index), and rom_rdata_i[64]; rom_rdata_i is valid the cycle after rom_req_o and holds until the next rom_req_o.

Function
REQ-012 SHALL have a read FSM with states R_IDLE, R_FETCH and R_SEND; arready_o is 1 only in R_IDLE.
REQ-013 SHALL, on an AR handshake, capture id, addr, len, size and burst, clear the beat counter, and enter R_FETCH.
REQ-014 SHALL assert rom_req_o for exactly one cycle in R_FETCH with rom_addr_o = (addr-BaseAddr)>>3, then enter R_SEND.
REQ-015 SHALL, in R_SEND, assert rvalid_o with rdata_o=rom_rdata_i, rid_o=captured id, and rlast_o=(beat==len), holding all of them stable until rready_i.
REQ-016 SHALL, on an R handshake, go to R_IDLE if it was the last beat; otherwise it SHALL increment the beat counter, update the address and go to R_FETCH.
REQ-017 SHALL have a latency of AR handshake in cycle N to first rvalid_o in N+2, and R handshake in M to the next rvalid_o in M+2.
REQ-018 SHALL update the address as follows: FIXED keeps it unchanged; INCR adds 1<<size; WRAP adds 1<<size and wraps within the aligned window of (len+1)<<size bytes. All arithmetic is AddrWidth wide.
REQ-019 SHALL treat the address as out of window if addr<BaseAddr or addr>=BaseAddr+RomBytes, evaluated per beat; such beats return rresp_o=DECERR and rdata_o=0 with no rom_req_o (R_FETCH is still traversed, so latency is unchanged).
REQ-020 SHALL return SLVERR with rdata_o=0 for every beat of a burst with arsize_i>3 or arburst_i=2'b11, with no rom_req_o.
REQ-021 SHALL otherwise return rresp_o=OKAY.
REQ-022 SHALL have a write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE, independent of the read FSM.
REQ-023 SHALL assert awready_o only in W_IDLE; an AW handshake captures awid_i.
REQ-024 SHALL assert wready_o only in W_DATA, discarding the data; a W handshake with wlast_i=1 moves to W_RESP.
REQ-025 SHALL, in W_RESP, assert bvalid_o with bresp_o=SLVERR and bid_o=captured id until bready_i, then return to W_IDLE.
REQ-026 SHALL allow reads and writes to proceed concurrently with no mutual stall.

Reset
REQ-027 SHALL, while rst_ni=0, force rvalid_o, rlast_o, bvalid_o, wready_o, rom_req_o, arready_o and awready_o to 0, and rid_o, rdata_o, rresp_o, bid_o and bresp_o to 0.
REQ-028 SHALL, on reset deassertion, enter R_IDLE and W_IDLE; arready_o and awready_o rise in the first clock after release.
REQ-029 SHALL abandon any burst in progress when reset is asserted mid-burst, emitting no further beats.

Configuration
REQ-030 SHALL support WRAP bursts per REQ-018 when macro BOOTROM_WRAP_BURST_EN is defined.
REQ-031 SHALL, when BOOTROM_WRAP_BURST_EN is undefined, treat WRAP like arburst_i=2'b11 per REQ-020: SLVERR on all len+1 beats, no rom_req_o, and no wrap adder synthesized.

Verification
REQ-032 SHALL cover: AR addr=0x1_0000, len=0, size=3, INCR -> rom_addr_o=0, one beat OKAY, rlast=1, rvalid in cycle N+2.
REQ-033 SHALL cover: AR addr=0x1_0008, len=3, INCR, rready held low for 3 cycles on beat 1 -> rom_addr_o 1,2,3,4, data stable while stalled, rlast on beat 3 only.
REQ-034 SHALL cover: AR addr=0x1_0018, len=3, size=3, WRAP -> with the macro, word indices 3,0,1,2; without it, 4 SLVERR beats.
REQ-035 SHALL cover: AR addr=0x1_FFF8, len=1, INCR -> beat 0 OKAY, beat 1 DECERR with rdata=0.
REQ-036 SHALL cover: AW id=5 followed by 4 W beats, concurrent with a read burst -> bresp=SLVERR, bid=5, and read beats unaffected.
REQ-037 SHALL cover: rst_ni pulsed low during beat 2 of a len=7 burst -> rvalid_o=0 immediately, arready_o=1 one cycle after release.

Source files
------------

// File: rtl/bootrom_axi_resp.sv
// bootrom_axi_resp: AXI4 read-only slave window onto a 64-bit boot ROM; writes are refused with SLVERR.
// Ports:
//   clk_i, rst_ni           clock, asynchronous active-low reset
//   ar*_i / arready_o       read address channel
//   r*_o / rready_i         read data channel (one ROM fetch per beat)
//   aw*_i / awready_o       write address channel (id captured only)
//   w*_i / wready_o         write data channel (data discarded)
//   b*_o / bready_i         write response channel (always SLVERR)
//   rom_req_o, rom_addr_o   one-cycle ROM read strobe and word index
//   rom_rdata_i             ROM word, valid the cycle after rom_req_o
// Build option: define BOOTROM_WRAP_BURST_EN to support WRAP bursts;
// otherwise WRAP is refused like the reserved burst type.
module bootrom_axi_resp #(
    parameter int unsigned AddrWidth = 64,
    parameter int unsigned DataWidth = 64,
    parameter int unsigned IdWidth   = 4,
    parameter logic [63:0] BaseAddr  = 64'h1_0000,
    parameter logic [63:0] RomBytes  = 64'h1_0000,
    localparam int unsigned RomAw    = $clog2(RomBytes / 8)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 arvalid_i,
    output logic                 arready_o,
    input  logic [IdWidth-1:0]   arid_i,
    input  logic [AddrWidth-1:0] araddr_i,
    input  logic [7:0]           arlen_i,
    input  logic [2:0]           arsize_i,
    input  logic [1:0]           arburst_i,
    output logic                 rvalid_o,
    input  logic                 rready_i,
    output logic [IdWidth-1:0]   rid_o,
    output logic [DataWidth-1:0] rdata_o,
    output logic [1:0]           rresp_o,
    output logic                 rlast_o,
    input  logic                 awvalid_i,
    output logic                 awready_o,
    input  logic [IdWidth-1:0]   awid_i,
    input  logic                 wvalid_i,
    output logic                 wready_o,
    input  logic                 wlast_i,
    output logic                 bvalid_o,
    input  logic                 bready_i,
    output logic [IdWidth-1:0]   bid_o,
    output logic [1:0]           bresp_o,
    output logic                 rom_req_o,
    output logic [RomAw-1:0]     rom_addr_o,
    input  logic [DataWidth-1:0] rom_rdata_i
);

    localparam logic [AddrWidth-1:0] Base  = AddrWidth'(BaseAddr);
    localparam logic [AddrWidth-1:0] Limit = AddrWidth'(BaseAddr + RomBytes);

    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_SEND} r_state_e;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;

    r_state_e               r_state_q;
    w_state_e               w_state_q;
    logic                   rdy_q;
    logic [IdWidth-1:0]     id_q, bid_q;
    logic [AddrWidth-1:0]   addr_q, addr_d, incr;
    logic [7:0]             len_q, beat_q;
    logic [2:0]             size_q;
    logic [1:0]             burst_q, resp;
    logic                   err_q, in_win, send, ar_hs, bad_burst;

    // rdy_q holds both address channels closed until the first clock after reset release
    assign arready_o  = rdy_q && r_state_q == R_IDLE;
    assign ar_hs      = arvalid_i && arready_o;
    assign send       = r_state_q == R_SEND;
    assign in_win     = addr_q >= Base && addr_q < Limit;
    assign resp       = err_q ? 2'b10 : in_win ? 2'b00 : 2'b11;
    assign rom_req_o  = r_state_q == R_FETCH && !err_q && in_win;
    assign rom_addr_o = RomAw'((addr_q - Base) >> 3);
    assign rvalid_o   = send;
    assign rid_o      = send ? id_q : '0;
    assign rresp_o    = send ? resp : 2'b00;
    assign rdata_o    = send && resp == 2'b00 ? rom_rdata_i : '0;
    assign rlast_o    = send && beat_q == len_q;
    assign incr       = addr_q + (AddrWidth'(1) << size_q);

`ifdef BOOTROM_WRAP_BURST_EN
    logic [AddrWidth-1:0] wrap_mask;
    // wrap window is (len+1)<<size bytes; only the bits inside it advance
    assign wrap_mask = ((AddrWidth'(len_q) + AddrWidth'(1)) << size_q) - AddrWidth'(1);
    assign addr_d    = burst_q == 2'b00 ? addr_q :
                       burst_q == 2'b10 ? (addr_q & ~wrap_mask) | (incr & wrap_mask) : incr;
    assign bad_burst = arburst_i == 2'b11;
`else
    assign addr_d    = burst_q == 2'b00 ? addr_q : incr;
    assign bad_burst = arburst_i[1];
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state_q <= R_IDLE;
            rdy_q     <= 1'b0;
            id_q      <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            beat_q    <= '0;
            size_q    <= '0;
            burst_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            rdy_q <= 1'b1;
            case (r_state_q)
                R_IDLE: if (ar_hs) begin
                    id_q      <= arid_i;
                    addr_q    <= araddr_i;
                    len_q     <= arlen_i;
                    size_q    <= arsize_i;
                    burst_q   <= arburst_i;
                    beat_q    <= '0;
                    err_q     <= arsize_i > 3'd3 || bad_burst;
                    r_state_q <= R_FETCH;
                end
                R_FETCH: r_state_q <= R_SEND;
                R_SEND: if (rready_i) begin
                    if (beat_q == len_q) r_state_q <= R_IDLE;
                    else begin
                        beat_q    <= beat_q + 8'd1;
                        addr_q    <= addr_d;
                        r_state_q <= R_FETCH;
                    end
                end
                default: r_state_q <= R_IDLE;
            endcase
        end
    end

    assign awready_o = rdy_q && w_state_q == W_IDLE;
    assign wready_o  = w_state_q == W_DATA;
    assign bvalid_o  = w_state_q == W_RESP;
    assign bid_o     = bvalid_o ? bid_q : '0;
    assign bresp_o   = bvalid_o ? 2'b10 : 2'b00;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            w_state_q <= W_IDLE;
            bid_q     <= '0;
        end else begin
            case (w_state_q)
                W_IDLE: if (awvalid_i && awready_o) begin
                    bid_q     <= awid_i;
                    w_state_q <= W_DATA;
                end
                W_DATA:  if (wvalid_i && wlast_i) w_state_q <= W_RESP;
                W_RESP:  if (bready_i) w_state_q <= W_IDLE;
                default: w_state_q <= W_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bootrom_axi_resp.sv
// tb_bootrom_axi_resp: table-driven and randomized checks of bootrom_axi_resp against a burst-level model.
module tb_bootrom_axi_resp;

    localparam logic [63:0] BASE = 64'h1_0000;
    localparam logic [63:0] ROMB = 64'h1_0000;
`ifdef BOOTROM_WRAP_BURST_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    logic clk = 1'b0, rst_ni = 1'b0;
    always #5 clk = ~clk;

    logic        arvalid = 1'b0, arready;
    logic [3:0]  arid = '0;
    logic [63:0] araddr = '0;
    logic [7:0]  arlen = '0;
    logic [2:0]  arsize = '0;
    logic [1:0]  arburst = '0;
    logic        rvalid, rready = 1'b0, rlast;
    logic [3:0]  rid;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic        awvalid = 1'b0, awready;
    logic [3:0]  awid = '0;
    logic        wvalid = 1'b0, wready, wlast = 1'b0;
    logic        bvalid, bready = 1'b0;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        rom_req;
    logic [12:0] rom_addr;
    logic [63:0] rom_rdata;

    int          cyc = 0, checks = 0, errors = 0, req_cnt = 0;
    logic [12:0] req_idx;

    bootrom_axi_resp dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .arvalid_i(arvalid), .arready_o(arready), .arid_i(arid), .araddr_i(araddr),
        .arlen_i(arlen), .arsize_i(arsize), .arburst_i(arburst),
        .rvalid_o(rvalid), .rready_i(rready), .rid_o(rid), .rdata_o(rdata),
        .rresp_o(rresp), .rlast_o(rlast),
        .awvalid_i(awvalid), .awready_o(awready), .awid_i(awid),
        .wvalid_i(wvalid), .wready_o(wready), .wlast_i(wlast),
        .bvalid_o(bvalid), .bready_i(bready), .bid_o(bid), .bresp_o(bresp),
        .rom_req_o(rom_req), .rom_addr_o(rom_addr), .rom_rdata_i(rom_rdata)
    );

    function automatic logic [63:0] rom_val(input logic [12:0] i);
        return {32'hB007_0000 | {19'b0, i}, ~{19'b0, i}};
    endfunction

    // ROM model: registered read, holds until next request; also logs requests
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rom_req) begin
            rom_rdata <= rom_val(rom_addr);
            req_cnt   <= req_cnt + 1;
            req_idx   <= rom_addr;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [1:0] exp_resp(input logic [63:0] a, input logic [2:0] size, input logic [1:0] burst);
        if (size > 3 || burst == 2'b11 || (burst == 2'b10 && !WRAP_EN)) return 2'b10;
        if (a < BASE || a >= BASE + ROMB) return 2'b11;
        return 2'b00;
    endfunction

    function automatic logic [63:0] nxt(input logic [63:0] a, input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
        logic [63:0] step, bytes, lo;
        step  = 64'd1 << size;
        bytes = (64'(len) + 64'd1) << size;
        lo    = a - (a % bytes);
        if (burst == 2'b00) return a;
        if (burst == 2'b10) return lo + ((a - lo + step) % bytes);
        return a + step;
    endfunction

    task automatic do_read(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input int sb, input int sn,
                           output logic [1:0] r0, output logic [1:0] rl);
        logic [63:0] a, d;
        logic [1:0]  er;
        int e, w, base;
        r0 = 2'b01;
        rl = 2'b01;
        @(negedge clk);
        arvalid = 1'b1; arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; rready = 1'b0;
        w = 0;
        while (!arready && w < 50) begin @(negedge clk); w++; end
        chk("ar_ready", 64'(arready), 64'd1);
        if (!arready) begin arvalid = 1'b0; return; end
        base = req_cnt;
        e = cyc + 1;
        @(negedge clk);
        arvalid = 1'b0;
        chk("ar_busy", 64'(arready), 64'd0);
        a = addr;
        for (int b = 0; b <= int'(len); b++) begin
            w = 0;
            while (!rvalid && w < 20) begin @(negedge clk); w++; end
            chk("r_valid", 64'(rvalid), 64'd1);
            if (!rvalid) return;
            chk("r_latency", 64'(cyc - e), 64'd1);
            er = exp_resp(a, size, burst);
            d  = er == 2'b00 ? rom_val(13'((a - BASE) >> 3)) : 64'd0;
            if (b == 0) r0 = rresp;
            if (b == int'(len)) rl = rresp;
            for (int s = 0; s <= (b == sb ? sn : 0); s++) begin
                if (s > 0) @(negedge clk);
                chk("r_valid_hold", 64'(rvalid), 64'd1);
                chk("r_data", rdata, d);
                chk("r_resp", 64'(rresp), 64'(er));
                chk("r_id", 64'(rid), 64'(id));
                chk("r_last", 64'(rlast), 64'(b == int'(len)));
            end
            chk("rom_req_cnt", 64'(req_cnt - base), er == 2'b00 ? 64'd1 : 64'd0);
            if (er == 2'b00) chk("rom_addr", 64'(req_idx), (a - BASE) >> 3);
            rready = 1'b1;
            base = req_cnt;
            e = cyc + 1;
            @(negedge clk);
            rready = 1'b0;
            chk("r_gap", 64'(rvalid), 64'd0);
            a = nxt(a, len, size, burst);
        end
        chk("ar_ready_after", 64'(arready), 64'd1);
    endtask

    task automatic do_write(input logic [3:0] id, input int n);
        int w;
        @(negedge clk);
        awvalid = 1'b1;
        awid = id;
        w = 0;
        while (!awready && w < 50) begin @(negedge clk); w++; end
        chk("aw_ready", 64'(awready), 64'd1);
        @(negedge clk);
        awvalid = 1'b0;
        chk("aw_busy", 64'(awready), 64'd0);
        for (int b = 0; b < n; b++) begin
            wvalid = 1'b1;
            wlast = b == n - 1;
            w = 0;
            while (!wready && w < 50) begin @(negedge clk); w++; end
            chk("w_ready", 64'(wready), 64'd1);
            @(negedge clk);
        end
        wvalid = 1'b0;
        wlast = 1'b0;
        w = 0;
        while (!bvalid && w < 50) begin @(negedge clk); w++; end
        chk("b_valid", 64'(bvalid), 64'd1);
        chk("b_id", 64'(bid), 64'(id));
        chk("b_resp", 64'(bresp), 64'd2);
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        chk("b_done", 64'(bvalid), 64'd0);
        chk("aw_ready_after", 64'(awready), 64'd1);
    endtask

    typedef struct {
        logic [63:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        int          sb, sn;
        logic [1:0]  r0, rl;
    } vec_t;

    vec_t        tbl[9];
    logic [1:0]  x0, x1, y0, y1, wr;
    logic [63:0] ra;
    logic [2:0]  rs;
    logic [1:0]  rb;
    logic [7:0]  rn;
    int          k, w;

    initial begin
        wr = WRAP_EN ? 2'b00 : 2'b10;
        tbl[0] = '{64'h1_0000, 8'd0, 3'd3, 2'b01, -1, 0, 2'b00, 2'b00};
        tbl[1] = '{64'h1_0008, 8'd3, 3'd3, 2'b01,  1, 3, 2'b00, 2'b00};
        tbl[2] = '{64'h1_0018, 8'd3, 3'd3, 2'b10, -1, 0, wr,    wr};
        tbl[3] = '{64'h1_FFF8, 8'd1, 3'd3, 2'b01, -1, 0, 2'b00, 2'b11};
        tbl[4] = '{64'h0_FFF8, 8'd1, 3'd3, 2'b01,  0, 2, 2'b11, 2'b00};
        tbl[5] = '{64'h1_0000, 8'd2, 3'd3, 2'b11, -1, 0, 2'b10, 2'b10};
        tbl[6] = '{64'h1_0000, 8'd1, 3'd4, 2'b01, -1, 0, 2'b10, 2'b10};
        tbl[7] = '{64'h1_0100, 8'd2, 3'd2, 2'b00, -1, 0, 2'b00, 2'b00};
        tbl[8] = '{64'h2_0000, 8'd0, 3'd3, 2'b01, -1, 0, 2'b11, 2'b11};

        repeat (3) @(negedge clk);
        chk("rst_arready", 64'(arready), 64'd0);
        chk("rst_awready", 64'(awready), 64'd0);
        chk("rst_rvalid", 64'(rvalid), 64'd0);
        chk("rst_bvalid", 64'(bvalid), 64'd0);
        chk("rst_wready", 64'(wready), 64'd0);
        chk("rst_rom_req", 64'(rom_req), 64'd0);
        chk("rst_outs", {rdata[31:0], 4'(rid), 4'(bid), 2'(rresp), 2'(bresp), 1'(rlast)}, 64'd0);
        rst_ni = 1'b1;
        #1 chk("rel_arready", 64'(arready), 64'd0);
        @(negedge clk);
        chk("rel_arready_up", 64'(arready), 64'd1);
        chk("rel_awready_up", 64'(awready), 64'd1);

        for (int i = 0; i < 9; i++) begin
            do_read(4'(i + 1), tbl[i].addr, tbl[i].len, tbl[i].size, tbl[i].burst, tbl[i].sb, tbl[i].sn, x0, x1);
            chk($sformatf("tbl%0d_resp_first", i), 64'(x0), 64'(tbl[i].r0));
            chk($sformatf("tbl%0d_resp_last", i), 64'(x1), 64'(tbl[i].rl));
        end

        fork
            do_read(4'd3, 64'h1_0040, 8'd7, 3'd3, 2'b01, 2, 2, y0, y1);
            do_write(4'd5, 4);
        join

        for (int i = 0; i < 40; i++) begin
            k  = $urandom_range(0, 9);
            ra = k < 6 ? BASE + 64'($urandom_range(0, 8191)) * 64'd8 :
                 k < 8 ? BASE + ROMB - 64'($urandom_range(1, 4)) * 64'd8 :
                         BASE - 64'($urandom_range(1, 3)) * 64'd8;
            ra = ra + 64'($urandom_range(0, 7));
            rb = 2'($urandom_range(0, 3));
            rs = 3'($urandom_range(0, 4));
            rn = rb == 2'b10 ? 8'((2 << $urandom_range(0, 2)) - 1) : 8'($urandom_range(0, 7));
            if (rs < 3'd4) ra = ra & ~((64'd1 << rs) - 64'd1);
            do_read(4'($urandom), ra, rn, rs, rb, $urandom_range(0, 7), $urandom_range(0, 3), x0, x1);
        end

        @(negedge clk);
        arvalid = 1'b1; arid = 4'd9; araddr = BASE; arlen = 8'd7; arsize = 3'd3; arburst = 2'b01;
        w = 0;
        while (!arready && w < 50) begin @(negedge clk); w++; end
        @(negedge clk);
        arvalid = 1'b0;
        for (int b = 0; b < 2; b++) begin
            w = 0;
            while (!rvalid && w < 20) begin @(negedge clk); w++; end
            rready = 1'b1;
            @(negedge clk);
            rready = 1'b0;
        end
        w = 0;
        while (!rvalid && w < 20) begin @(negedge clk); w++; end
        chk("mid_beat2_valid", 64'(rvalid), 64'd1);
        chk("mid_beat2_data", rdata, rom_val(13'd2));
        rst_ni = 1'b0;
        #1;
        chk("mid_rst_rvalid", 64'(rvalid), 64'd0);
        chk("mid_rst_arready", 64'(arready), 64'd0);
        chk("mid_rst_rdata", rdata, 64'd0);
        chk("mid_rst_rlast", 64'(rlast), 64'd0);
        @(negedge clk);
        rst_ni = 1'b1;
        #1 chk("mid_rel_arready", 64'(arready), 64'd0);
        @(negedge clk);
        chk("mid_rel_arready_up", 64'(arready), 64'd1);
        rready = 1'b1;
        repeat (4) @(negedge clk);
        chk("mid_no_beats", 64'(rvalid), 64'd0);
        rready = 1'b0;
        do_read(4'd6, 64'h1_0010, 8'd0, 3'd3, 2'b01, -1, 0, x0, x1);
        chk("post_rst_resp", 64'(x0), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
